// File: rtl/idu_ingress.sv
// idu_ingress: IFU->IDU receiver with pre-decode and a small decoupling FIFO.
// Ports: clk/rst(async low)/flush; ifu_valid/ifu_data -> idu_ready;
//        exu_valid/exu_ready plus decoded head fields exu_pc..exu_illegal.
module idu_ingress #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               ifu_valid,
    input  logic [2*WIDTH-1:0] ifu_data,
    output logic               idu_ready,
    output logic               exu_valid,
    input  logic               exu_ready,
    output logic [WIDTH-1:0]   exu_pc,
    output logic [WIDTH-1:0]   exu_inst,
    output logic [4:0]         exu_rd,
    output logic [4:0]         exu_rs1,
    output logic [4:0]         exu_rs2,
    output logic [WIDTH-1:0]   exu_imm,
    output logic [2:0]         exu_fmt,
    output logic               exu_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       fmt;
        logic             ill;
    } ent_t;

    logic [WIDTH-1:0] w_inst;
    logic [6:0]       w_op;
    logic [31:0]      w_imm32;
    logic [2:0]       w_fmt;
    logic             w_ill;
    ent_t             w_dec;
    ent_t             w_head;
    ent_t             r_mem [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_live;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_inst = ifu_data[2*WIDTH-1:WIDTH];
    assign w_op   = w_inst[6:0];

    always_comb begin
        w_fmt   = FMT_R;
        w_ill   = 1'b0;
        w_imm32 = '0;
        case (w_op)
            7'b0110111, 7'b0010111: begin
                w_fmt   = FMT_U;
                w_imm32 = {w_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt   = FMT_J;
                w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                           w_inst[20], w_inst[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b1110011, 7'b0001111: begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            7'b0100011: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            7'b1100011: begin
                w_fmt   = FMT_B;
                w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                           w_inst[30:25], w_inst[11:8], 1'b0};
            end
            7'b0110011: w_fmt = FMT_R;
            default:    w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_dec.pc   = ifu_data[WIDTH-1:0];
        w_dec.inst = w_inst;
        w_dec.imm  = {{(WIDTH-31){w_imm32[31]}}, w_imm32[30:0]};
        w_dec.rd   = w_inst[11:7];
        w_dec.rs1  = w_inst[19:15];
        w_dec.rs2  = w_inst[24:20];
        w_dec.fmt  = w_fmt;
        w_dec.ill  = w_ill;
    end

    // idu_ready depends only on registered state; r_live holds it low
    // through reset and for nothing longer than the first edge after.
    assign w_full    = (r_count == CW'(DEPTH));
    assign idu_ready = r_live & ~w_full;
    assign exu_valid = (r_count != '0);
    assign w_push    = ifu_valid & idu_ready & ~flush;
    assign w_pop     = exu_valid & exu_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + AW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_dec;
    end

    // Outputs are forced to zero when empty so they read 0 in reset and
    // never wander while exu_valid is low.
    assign w_head      = r_mem[r_rptr];
    assign exu_pc      = exu_valid ? w_head.pc   : '0;
    assign exu_inst    = exu_valid ? w_head.inst : '0;
    assign exu_imm     = exu_valid ? w_head.imm  : '0;
    assign exu_rd      = exu_valid ? w_head.rd   : '0;
    assign exu_rs1     = exu_valid ? w_head.rs1  : '0;
    assign exu_rs2     = exu_valid ? w_head.rs2  : '0;
    assign exu_fmt     = exu_valid ? w_head.fmt  : '0;
    assign exu_illegal = exu_valid & w_head.ill;

endmodule

// File: doc/idu_ingress.md
Name: idu_ingress

Overview:
- Decode-side receiver for the IFU→IDU valid/ready interface. Accepts 64-bit fetch bundles {inst, pc}.
- Each bundle is pre-decoded at enqueue: register indices, sign-extended immediate, format class and an illegal flag.
- Decoded entries sit in a 2-entry FIFO and are presented to the EXU over a second valid/ready handshake.
- Decouples EXU back-pressure from the IFU: idu_ready is registered-state only, with no combinational path from exu_ready.

Parameters:
- WIDTH, 32, instruction/PC width; the bundle is 2*WIDTH bits.
- DEPTH, 2, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  discard all buffered entries (redirect)
- ifu_valid  input  1  fetch bundle valid
- ifu_data  input  64  [63:32] inst, [31:0] pc
- idu_ready  output  1  space available; equals !full
- exu_valid  output  1  head entry valid
- exu_ready  input  1  EXU accepts head
- exu_pc  output  32  head PC
- exu_inst  output  32  head raw instruction
- exu_rd  output  5  inst[11:7]
- exu_rs1  output  5  inst[19:15]
- exu_rs2  output  5  inst[24:20]
- exu_imm  output  32  sign-extended immediate per format
- exu_fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J
- exu_illegal  output  1  unsupported encoding

Behaviour:
- Reset (rst=0, asynchronous) clears count and read/write pointers. While in reset: idu_ready=0, exu_valid=0, and all other exu_* outputs read 0.
- After reset deasserts, idu_ready=1 from the first clock edge.
- Enqueue when ifu_valid && idu_ready at a posedge. Decode is computed combinationally from ifu_data and stored with the entry.
- Dequeue when exu_valid && exu_ready at a posedge.
- exu_* outputs reflect the head entry. exu_valid = (count != 0).
- Latency: a bundle accepted at edge N is visible on exu_* immediately after edge N when the FIFO was empty (1-cycle latency).
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal at any count less than DEPTH.
- Full: idu_ready=0. ifu_valid is ignored, and the IFU must hold its data.
- A dequeue while full raises idu_ready on the next cycle, not the same cycle.
- Empty: exu_valid=0. exu_* data is don't-care but must not change while exu_valid=0.
- Pointers wrap modulo DEPTH. Count has log2(DEPTH)+1 bits.
- flush=1 at a posedge: count and pointers go to 0, and any same-cycle enqueue or dequeue is discarded. Next cycle: exu_valid=0, idu_ready=1.
- Stability: while exu_valid && !exu_ready, all exu_* outputs stay stable.
- Decode rules by opcode inst[6:0]:
  - 0110111 / 0010111 → U: imm = {inst[31:12], 12'b0}
  - 1101111 → J: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - 1100111 / 0000011 / 0010011 / 1110011 / 0001111 → I: imm = sext(inst[31:20])
  - 0100011 → S: imm = sext({inst[31:25], inst[11:7]})
  - 1100011 → B: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - 0110011 → R: imm = 0
  - Any other opcode → illegal=1, fmt=R, imm=0.
- Reset mid-operation: all buffered entries are lost. No partial handshake completes across reset.

Test Plan:
- Single op: push ifu_data = {0x00500093, 0x80000000}, exu_ready=1 → next cycle exu_valid=1, pc=0x80000000, rd=1, rs1=0, imm=0x00000005, fmt=1, illegal=0; one cycle later exu_valid=0.
- Branch imm: inst 0xFE000EE3 → fmt=3, rs1=0, rs2=0, imm=0xFFFFFFFC. Inst 0x008000EF → fmt=5, rd=1, imm=0x00000008.
- Back-pressure: exu_ready=0, push pc 0x0 and 0x4 → idu_ready=0 after the second push and a third bundle (pc 0x8) is held. Raise exu_ready → heads emerge in order 0x0, 0x4, 0x8, and exu_* stays stable during stall cycles.
- Concurrent push/pop: count=1, ifu_valid=1 and exu_ready=1 for 8 cycles with pc incrementing by 4 → one entry per cycle in order, count stays 1, idu_ready stays 1.
- Flush: two entries buffered, flush=1 with ifu_valid=1 → next cycle exu_valid=0, idu_ready=1, and the flushed-cycle bundle never appears.
- Illegal and reset: inst 0x00000000 → illegal=1. With 2 entries buffered, assert rst=0 asynchronously mid-cycle → exu_valid and idu_ready drop immediately, and no entry survives after release.
